mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter shared by the instruction-fetch stage and the data-access (load/store) path of the pipelined processor. Each cycle it accepts at most one pending request and drives the memory port for a fixed number of cycles. It returns read data with a one-cycle ready pulse. Data accesses have priority, with a fairness guard so fetch is never starved.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles, ≥1; `mem_rdata` is valid in the MEM_LAT-th cycle of `mem_en`
- FAIR_MAX, 3, consecutive data grants allowed while fetch waits

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until `if_ready`
- if_addr  in  ADDR_W  fetch address, stable while `if_req` is high
- if_rdata  out  DATA_W  fetched word, valid when `if_ready`
- if_ready  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until `d_ready`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when `d_ready`
- d_ready  out  1  one-cycle completion pulse
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: arbitrates.
  - BUSY_F: drives the port for fetch.
  - BUSY_D: drives the port for data.
  - DONE: pulses ready; no arbitration in this state.
- IDLE transitions:
  - Only `d_req` high → BUSY_D.
  - Only `if_req` high → BUSY_F.
  - Both high → BUSY_D, unless `streak == FAIR_MAX`, in which case → BUSY_F.
  - Neither high → stay in IDLE.
- Entering BUSY_x: register `mem_addr`, `mem_we` (always 0 for fetch; `d_we` for data) and `mem_wdata`; set `cnt` to 0.
- BUSY_x:
  - `mem_en` is 1 and all memory outputs are held stable.
  - `cnt` increments every cycle.
  - When `cnt == MEM_LAT-1`, capture `mem_rdata` into `x_rdata` and go to DONE.
- DONE: assert the granted requester's ready for exactly one cycle, then go to IDLE.
  - The requester may drop `req` or present a new access in this cycle; the arbiter does not sample requests in DONE.
- Stores follow the same timing. `d_rdata` for a store is unspecified but is updated from `mem_rdata`.
- Fairness counter `streak`:
  - Increments on a data grant made while `if_req` is high, saturating at FAIR_MAX.
  - Clears on any fetch grant.
  - Holds its value on a data grant made while `if_req` is low.
- `if_rdata` and `d_rdata` hold their last captured value until the next capture for that requester.
- Dropping `req` mid-access does not abort the access; ready still pulses.

## Timing
- Reset (`rst` high at a clock edge) forces:
  - state IDLE, `cnt` 0, `streak` 0;
  - `mem_en`, `mem_we`, `if_ready`, `d_ready`, `busy` all 0;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` all 0.
- Reset mid-access abandons the access with no ready pulse. A store interrupted by reset counts as not performed.
- Request seen in IDLE at cycle 0 gives:
  - `mem_en` high in cycles 1..MEM_LAT;
  - ready high in cycle MEM_LAT+1;
  - IDLE in cycle MEM_LAT+2.
- Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Simultaneous requests in IDLE resolve in the same edge; the loser's request stays pending with no side effects.
- `cnt` width is $clog2(MEM_LAT+1); the counter never wraps, because the state machine leaves BUSY at MEM_LAT-1.
- `if_ready` and `d_ready` are never high in the same cycle. `mem_en` is never high in IDLE or DONE.

## Structure
- Shared package `arb_pkg`:
  - `arb_state_t` enum (IDLE, BUSY_F, BUSY_D, DONE);
  - `grant_t` enum (GNT_F, GNT_D);
  - default MEM_LAT and FAIR_MAX constants.
- Single module with no sub-module: the state machine, `cnt`, `streak` and the capture registers fit in one block.
- The processor connects `stall_D` and `flush_F` using `if_req & ~if_ready` at the top level, not inside this block.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=0x100, memory returns 0xDEADBEEF.
  - Required: `mem_en` in cycles 1–2 with `mem_addr`=0x100 and `mem_we`=0.
  - Required: `if_ready`=1 and `if_rdata`=0xDEADBEEF in cycle 3; IDLE in cycle 4.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x200, `d_wdata`=0x12345678.
  - Required: `mem_we`=1 and `mem_wdata`=0x12345678 in cycles 1–2; `d_ready` in cycle 3.
  - Required: a following load of 0x200 returns 0x12345678.
- Contention: `if_req` and `d_req` held high continuously with FAIR_MAX=3.
  - Required grant order: D, D, D, F, D, D, D, F, with every grant 4 cycles apart.
- Reset mid-access: `rst` asserted in cycle 2 of a data load.
  - Required: cycle 3 has IDLE, `mem_en`=0, no `d_ready`, `streak`=0 and all outputs 0.
- Request change in DONE: fetch holds `if_req` high and changes `if_addr` 0x100→0x104 during its `if_ready` cycle.
  - Required: the next access uses 0x104 and exactly one ready pulse is produced per access.
- Dropped request: `d_req` deasserted in cycle 1 of a data access.
  - Required: the access completes and `d_ready` still pulses in cycle 3.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default timing constants for the fetch/data memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_F = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam int unsigned MEM_LAT_DEF  = 2;
  localparam int unsigned FAIR_MAX_DEF = 3;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store data path.
// Data wins contention; after FAIR_MAX back-to-back data wins over a waiting fetch, fetch gets the port.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_LAT  = MEM_LAT_DEF,
  parameter int unsigned FAIR_MAX = FAIR_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned STK_W = (FAIR_MAX > 0) ? $clog2(FAIR_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(FAIR_MAX);

  arb_state_t        state_q,     state_d;
  grant_t            grant_q,     grant_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [STK_W-1:0]  streak_q,    streak_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic              if_ready_q,  if_ready_d;
  logic              d_ready_q,   d_ready_d;
  logic              busy_q,      busy_d;
  logic              take_d_s;

  // A waiting fetch overrides data only once the streak has saturated.
  assign take_d_s = d_req & ~(if_req & (streak_q == STK_MAX));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (take_d_s) begin
          state_d     = BUSY_D;
          grant_d     = GNT_D;
          cnt_d       = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (if_req && (streak_q != STK_MAX)) begin
            streak_d = streak_q + STK_W'(1);
          end else begin
            streak_d = streak_q;
          end
        end else if (if_req) begin
          state_d     = BUSY_F;
          grant_d     = GNT_F;
          cnt_d       = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_F, BUSY_D: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          mem_we_d = 1'b0;
          if (grant_q == GNT_F) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end
        end else begin
          mem_en_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= GNT_F;
      cnt_q       <= '0;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign busy      = busy_q;

endmodule
